// File: rtl/step_pulse_gen_pkg.sv
// Shared constants and state encoding for the step pulse generator.
package step_pulse_gen_pkg;

  localparam int MIN_PHASE_DEF = 2;
  localparam int DIR_SETUP_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIR,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command/status bundle between a motion controller and step_pulse_gen.
interface step_pulse_gen_if #(
  parameter int COUNT_WIDTH = 16,
  parameter int TIME_WIDTH  = 16
);

  logic                   start;
  logic                   abort;
  logic [COUNT_WIDTH-1:0] step_count;
  logic                   direction_in;
  logic [TIME_WIDTH-1:0]  high_time;
  logic [TIME_WIDTH-1:0]  low_time;
  logic                   step_out;
  logic                   direction_out;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] steps_done;

  modport master (
    output start, abort, step_count, direction_in,
    output high_time, low_time,
    input  step_out, direction_out, busy, done, steps_done
  );

  modport slave (
    input  start, abort, step_count, direction_in,
    input  high_time, low_time,
    output step_out, direction_out, busy, done, steps_done
  );

endinterface

// File: rtl/step_pulse_gen_phase_timer.sv
// Loadable down-counter with zero flag; times the DIR, HI and LO phases.
module phase_timer #(
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [TIME_WIDTH-1:0] i_value,
  output logic                  o_zero
);

  localparam logic [TIME_WIDTH-1:0] LP_ONE = TIME_WIDTH'(1);

  logic [TIME_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LP_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse train generator with direction setup and abort.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int TIME_WIDTH  = 16,
  parameter int DIR_SETUP   = DIR_SETUP_DEF,
  parameter int MIN_PHASE   = MIN_PHASE_DEF
) (
  input logic          clk,
  input logic          reset,
  step_pulse_gen_if.slave bus
);

  localparam logic [TIME_WIDTH-1:0]  LP_ONE  = TIME_WIDTH'(1);
  localparam logic [TIME_WIDTH-1:0]  LP_MIN  = TIME_WIDTH'(MIN_PHASE);
  localparam logic [TIME_WIDTH-1:0]  LP_DIR  = TIME_WIDTH'(DIR_SETUP - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_CONE = COUNT_WIDTH'(1);

  state_t r_state;
  state_t w_next;

  logic [TIME_WIDTH-1:0]  r_high;
  logic [TIME_WIDTH-1:0]  r_low;
  logic [COUNT_WIDTH-1:0] r_rem;
  logic [COUNT_WIDTH-1:0] r_steps;
  logic                   r_dir;
  logic                   r_abort_pend;

  logic                  w_load;
  logic                  w_zero;
  logic [TIME_WIDTH-1:0] w_val;
  logic [TIME_WIDTH-1:0] w_hi_len;
  logic [TIME_WIDTH-1:0] w_lo_len;
  logic                  w_accept;
  logic                  w_hi_end;

  // Timer is loaded with duration-1 so the zero flag marks the last cycle.
  assign w_hi_len = (r_high < LP_MIN) ? LP_MIN - LP_ONE : r_high - LP_ONE;
  assign w_lo_len = (r_low < LP_MIN) ? LP_MIN - LP_ONE : r_low - LP_ONE;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_hi_end = (r_state == S_HI) && w_zero;

  phase_timer #(
    .TIME_WIDTH(TIME_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_val  = LP_DIR;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = (bus.step_count == '0) ? S_DONE : S_DIR;
        end
      end
      S_DIR: begin
        if (bus.abort) begin
          w_next = S_DONE;
        end else if (w_zero) begin
          w_next = S_HI;
          w_load = 1'b1;
          w_val  = w_hi_len;
        end
      end
      S_HI: begin
        if (w_zero) begin
          w_load = 1'b1;
          w_val  = w_lo_len;
          w_next = (bus.abort || r_abort_pend) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        if (bus.abort) begin
          w_next = S_DONE;
        end else if (w_zero) begin
          if (r_rem != '0) begin
            w_next = S_HI;
            w_load = 1'b1;
            w_val  = w_hi_len;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_high       <= '0;
      r_low        <= '0;
      r_rem        <= '0;
      r_steps      <= '0;
      r_dir        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_high  <= bus.high_time;
        r_low   <= bus.low_time;
        r_rem   <= bus.step_count;
        r_steps <= '0;
        if (bus.step_count != '0) begin
          r_dir <= bus.direction_in;
        end
      end
      if (w_hi_end) begin
        r_steps <= r_steps + LP_CONE;
        r_rem   <= r_rem - LP_CONE;
      end
      // An abort seen anywhere in the high phase ends the move after it.
      if (r_state == S_HI) begin
        r_abort_pend <= !w_zero && (r_abort_pend || bus.abort);
      end else begin
        r_abort_pend <= 1'b0;
      end
    end
  end

  assign bus.step_out      = (r_state == S_HI);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.direction_out = r_dir;
  assign bus.steps_done    = r_steps;

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter COUNT_WIDTH, default 16, width of step count and progress count.
REQ-002 Parameter TIME_WIDTH, default 16, width of phase-time operands.
REQ-003 Parameter DIR_SETUP, default 4, clock cycles that direction_out is stable before the first step_out rise.
REQ-004 Parameter MIN_PHASE, default 2, minimum cycles for each high or low phase.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  command strobe; sampled only in S_IDLE.
REQ-008 abort  input  1  level; requests early termination of the current move.
REQ-009 step_count  input  COUNT_WIDTH  number of pulses to emit, unsigned.
REQ-010 direction_in  input  1  move direction: 1 = up, 0 = down.
REQ-011 high_time  input  TIME_WIDTH  step_out high duration in cycles.
REQ-012 low_time  input  TIME_WIDTH  step_out low duration in cycles.
REQ-013 step_out  output  1  generated pulse train.
REQ-014 direction_out  output  1  registered direction, paired with step_out.
REQ-015 busy  output  1  high in every state except S_IDLE.
REQ-016 done  output  1  one-cycle strobe at the end of a move, whether completed or aborted.
REQ-017 steps_done  output  COUNT_WIDTH  pulses emitted in the current or last move.

Function
REQ-018 The FSM SHALL be a registered-state Moore machine with states S_IDLE, S_DIR, S_HI, S_LO and S_DONE.
REQ-019 On start=1 in S_IDLE, the block SHALL latch step_count, direction_in, high_time and low_time, clear steps_done, and go to S_DIR.
REQ-020 Latched step_count = 0: the FSM SHALL go to S_DONE instead of S_DIR, emitting no pulses; direction_out is not updated.
REQ-021 start while busy SHALL be ignored; changes to the command inputs after the latch SHALL have no effect.
REQ-022 direction_out SHALL update only on the S_IDLE->S_DIR transition; S_DIR SHALL last exactly DIR_SETUP cycles, then go to S_HI.
REQ-023 The block SHALL drive step_out = (state == S_HI) from registered state only, so it is glitch-free.
REQ-024 S_HI SHALL last max(high_time, MIN_PHASE) cycles; on exit, steps_done increments by 1 and remaining decrements by 1.
REQ-025 S_LO SHALL last max(low_time, MIN_PHASE) cycles; on exit, go to S_HI if remaining != 0, else to S_DONE.
REQ-026 S_DONE SHALL last 1 cycle with done=1, then go to S_IDLE.
REQ-027 Abort in S_DIR or S_LO SHALL go to S_DONE on the next cycle.
REQ-028 Abort in S_HI SHALL complete the current high phase (no runt pulse), count that pulse, then go to S_DONE, skipping S_LO.
REQ-029 Abort in S_IDLE or S_DONE SHALL be ignored; abort and start together in S_IDLE SHALL accept start.
REQ-030 steps_done SHALL hold its value in S_IDLE until the next accepted start; it never wraps because it is bounded by the latched step_count.
REQ-031 First-pulse latency: start sampled at edge 0 SHALL give the step_out rise at edge 1+DIR_SETUP.
REQ-032 Pulse period SHALL be max(high_time,MIN_PHASE) + max(low_time,MIN_PHASE) cycles.
REQ-033 Total busy time for N pulses SHALL be DIR_SETUP + N*period + 1 cycles.

Reset
REQ-034 While reset=0, the block SHALL force state to S_IDLE and step_out, direction_out, busy, done to 0, and steps_done and all timers to 0.
REQ-035 Reset asserted mid-move SHALL abandon the move immediately with no done strobe.
REQ-036 After reset release, the block SHALL require a new start before emitting any pulse.

Structure
REQ-037 The state enum and the MIN_PHASE and DIR_SETUP defaults SHALL live in the shared global constants package.
REQ-038 Phase timing SHALL use one sub-module, phase_timer: a loadable down-counter of TIME_WIDTH with a zero flag, shared by S_DIR, S_HI and S_LO.
REQ-039 The remaining-step counter and steps_done register SHALL be local to step_pulse_gen.

Verification
REQ-040 step_count=3, dir=1, high=4, low=6 -> 3 pulses 4 cycles high, 10-cycle period, first rise at start+5, done at start+35, steps_done=3.
REQ-041 step_count=0 -> no step_out activity; busy for 1 cycle; done 1 cycle after start; steps_done=0.
REQ-042 high=0, low=1 -> each phase stretched to 2 cycles (MIN_PHASE); pulse period 4.
REQ-043 step_count=10, abort during the 3rd high phase -> that pulse completes at full width; done follows; steps_done=3; no 4th rise.
REQ-044 Loop-back into the existing up/down pulse counter: 5 steps up then 3 down -> net count +2, no missed or extra counts.
REQ-045 reset asserted during S_HI -> step_out=0 asynchronously; no done; subsequent start behaves as from power-up.
